shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter/rotator for the NPC execute path. It extends the single-cycle 32-bit shifter with configurable data width and pipeline depth, rotate modes, an in-order tag sideband, and a valid/ready handshake with backpressure and flush. It sits between issue and writeback as a multi-cycle functional unit.

---
 rtl/shift_pipe.sv | 159 +++++++++++++++
 tb/tb_shift_pipe.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter/rotator with an in-order tag sideband and valid/ready flow control.
// Shift levels run largest-first and are spread evenly over PIPE_STAGES register stages.
module shift_pipe #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned PIPE_STAGES = 2,
  parameter int unsigned TAG_W       = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_data,
  input  logic [$clog2(XLEN)-1:0]   in_amt,
  input  logic [2:0]                in_fn,
  input  logic [TAG_W-1:0]          in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_data,
  output logic [TAG_W-1:0]          out_tag
);

  localparam int unsigned LEVELS = $clog2(XLEN);
  localparam int unsigned AMT_W  = LEVELS;
  localparam int unsigned LAST   = PIPE_STAGES - 1;

  localparam logic [2:0] FN_SLL = 3'b000;
  localparam logic [2:0] FN_SRL = 3'b001;
  localparam logic [2:0] FN_SRA = 3'b011;
  localparam logic [2:0] FN_ROL = 3'b100;
  localparam logic [2:0] FN_ROR = 3'b101;

  function automatic logic fn_supported(input logic [2:0] fn);
    logic ok;
    ok = 1'b0;
    case (fn)
      FN_SLL, FN_SRL, FN_SRA, FN_ROL, FN_ROR: ok = 1'b1;
      default:                                ok = 1'b0;
    endcase
    return ok;
  endfunction

  // One shift level by a fixed distance k; SRA fills from the sign captured at accept.
  function automatic logic [XLEN-1:0] level_op(input logic [XLEN-1:0] d,
                                               input logic [2:0]      fn,
                                               input logic            sign,
                                               input int unsigned     k);
    logic [XLEN-1:0] r;
    r = '0;
    case (fn)
      FN_SLL:  r = d << k;
      FN_SRL:  r = d >> k;
      FN_SRA:  r = (d >> k) | (sign ? ~({XLEN{1'b1}} >> k) : '0);
      FN_ROL:  r = (d << k) | (d >> (XLEN - k));
      FN_ROR:  r = (d >> k) | (d << (XLEN - k));
      default: r = '0;
    endcase
    return r;
  endfunction

  for (genvar s = 0; s < int'(PIPE_STAGES); s++) begin : g_stage
    // Amount bits still needed by the stages after this one (the low-order bits).
    localparam int unsigned FIRST_NEXT = ((s + 1) * LEVELS + PIPE_STAGES - 1) / PIPE_STAGES;
    localparam int unsigned REM        = LEVELS - FIRST_NEXT;

    logic              src_valid;
    logic [XLEN-1:0]   src_data;
    logic [AMT_W-1:0]  src_amt;
    logic [2:0]        src_fn;
    logic              src_sign;
    logic [TAG_W-1:0]  src_tag;
    logic [XLEN-1:0]   nxt_data;
    logic              room;

    logic              valid_q;
    logic [XLEN-1:0]   data_q;
    logic [TAG_W-1:0]  tag_q;

    if (s == 0) begin : g_src
      // Unsupported modes start from zero so every level leaves the result at zero.
      always_comb begin
        src_valid = in_valid && in_ready;
        src_data  = fn_supported(in_fn) ? in_data : '0;
        src_amt   = in_amt;
        src_fn    = in_fn;
        src_sign  = in_data[XLEN-1];
        src_tag   = in_tag;
      end
    end else begin : g_src
      always_comb begin
        src_valid = g_stage[s-1].valid_q;
        src_data  = g_stage[s-1].data_q;
        src_amt   = AMT_W'(g_stage[s-1].g_ctl.amt_q);
        src_fn    = g_stage[s-1].g_ctl.fn_q;
        src_sign  = g_stage[s-1].g_ctl.sign_q;
        src_tag   = g_stage[s-1].tag_q;
      end
    end

    // A stage may load when it is empty or everything downstream is moving.
    if (s == int'(LAST)) begin : g_room
      assign room = out_ready || !valid_q;
    end else begin : g_room
      assign room = g_stage[s+1].room || !valid_q;
    end

    always_comb begin : p_shift
      nxt_data = src_data;
      for (int j = 0; j < int'(LEVELS); j++) begin
        if (((j * int'(PIPE_STAGES)) / int'(LEVELS) == s) &&
            (((src_amt >> (int'(LEVELS) - 1 - j)) & AMT_W'(1)) != '0)) begin
          nxt_data = level_op(nxt_data, src_fn, src_sign, XLEN >> (j + 1));
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else begin
        if (flush) begin
          valid_q <= 1'b0;
        end else if (room) begin
          valid_q <= src_valid;
        end
        if (room && src_valid) begin
          data_q <= nxt_data;
          tag_q  <= src_tag;
        end
      end
    end

    if (s < int'(LAST)) begin : g_ctl
      logic [REM-1:0] amt_q;
      logic [2:0]     fn_q;
      logic           sign_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          amt_q  <= '0;
          fn_q   <= '0;
          sign_q <= 1'b0;
        end else if (room && src_valid) begin
          amt_q  <= src_amt[REM-1:0];
          fn_q   <= src_fn;
          sign_q <= src_sign;
        end
      end
    end
  end

  assign in_ready  = !flush && g_stage[0].room;
  assign out_valid = g_stage[LAST].valid_q;
  assign out_data  = g_stage[LAST].data_q;
  assign out_tag   = g_stage[LAST].tag_q;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboard bench for shift_pipe (XLEN=32, PIPE_STAGES=2): reference model results
// are queued at accept and compared when the unit hands a result to the consumer.
module tb_shift_pipe;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned PS    = 2;
  localparam int unsigned TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  in_data;
  logic [4:0]       in_amt;
  logic [2:0]       in_fn;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  shift_pipe #(.XLEN(XLEN), .PIPE_STAGES(PS), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_amt(in_amt), .in_fn(in_fn), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned chk_cnt = 0;
  int unsigned pass_cnt = 0;
  int unsigned out_cnt = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] a,
                                        input logic [2:0] fn);
    logic [63:0] dd;
    logic [31:0] r;
    dd = {d, d};
    r  = '0;
    case (fn)
      3'b000:  r = d << a;
      3'b001:  r = d >> a;
      3'b011:  r = 32'($signed(d) >>> a);
      3'b100:  begin dd = dd << a; r = dd[63:32]; end
      3'b101:  begin dd = dd >> a; r = dd[31:0];  end
      default: r = '0;
    endcase
    return r;
  endfunction

  // Scoreboard: pop on output handshake, drop in-flight work on flush, push on accept.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        exp_t e;
        out_cnt++;
        chk_cnt++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: got tag=%0d data=%h, expected no output", out_tag, out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data || out_tag !== e.tag)
            $display("FAIL sb_result: got tag=%0d data=%h, expected tag=%0d data=%h",
                     out_tag, out_data, e.tag, e.data);
          else
            pass_cnt++;
        end
      end
      if (flush) exp_q.delete();
      if (in_valid && in_ready) exp_q.push_back('{data: model(in_data, in_amt, in_fn), tag: in_tag});
    end
  end

  logic [31:0] d_tab [12] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0001, 32'h1234_5678,
                              32'h1234_5678, 32'hA5A5_F00F, 32'hA5A5_F00F, 32'hA5A5_F00F,
                              32'hA5A5_F00F, 32'hA5A5_F00F, 32'hDEAD_BEEF, 32'h0000_0001};
  logic [4:0]  a_tab [12] = '{5'd31, 5'd31, 5'd31, 5'd8, 5'd4, 5'd0, 5'd0, 5'd0,
                              5'd0, 5'd0, 5'd5, 5'd0};
  logic [2:0]  f_tab [12] = '{3'b011, 3'b001, 3'b000, 3'b101, 3'b100, 3'b000, 3'b001,
                              3'b011, 3'b100, 3'b101, 3'b010, 3'b111};
  logic [31:0] e_tab [12] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h8000_0000, 32'h7812_3456,
                              32'h2345_6781, 32'hA5A5_F00F, 32'hA5A5_F00F, 32'hA5A5_F00F,
                              32'hA5A5_F00F, 32'hA5A5_F00F, 32'h0000_0000, 32'h0000_0000};

  task automatic test_reset();
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    chk_cnt++;
    if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", out_data);
    else pass_cnt++;
    chk_cnt++;
    if (out_tag !== '0) $display("FAIL reset_out_tag: got %0d expected 0", out_tag);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL reset_idle_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
  endtask

  task automatic test_modes();
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = d_tab[i];
      in_amt   = a_tab[i];
      in_fn    = f_tab[i];
      in_tag   = 5'(i + 1);
      @(negedge clk);
      chk_cnt++;
      if (in_ready !== 1'b1) $display("FAIL mode%0d_in_ready: got %b expected 1", i, in_ready);
      else pass_cnt++;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk_cnt++;
      if (out_valid !== 1'b0) $display("FAIL mode%0d_early: got out_valid=%b expected 0", i, out_valid);
      else pass_cnt++;
      @(negedge clk);
      chk_cnt++;
      if (out_valid !== 1'b1 || out_data !== e_tab[i] || out_tag !== 5'(i + 1))
        $display("FAIL mode%0d_result: got v=%b data=%h tag=%0d expected v=1 data=%h tag=%0d",
                 i, out_valid, out_data, out_tag, e_tab[i], i + 1);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      if (k < 4) begin
        in_valid = 1'b1;
        in_data  = $urandom;
        in_amt   = 5'($urandom_range(0, 31));
        in_fn    = 3'($urandom_range(0, 7));
        in_tag   = 5'(k + 1);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 4) begin
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL b2b_in_ready%0d: got %b expected 1", k, in_ready);
        else pass_cnt++;
      end
      chk_cnt++;
      if (k >= 2) begin
        if (out_valid !== 1'b1 || out_tag !== 5'(k - 1))
          $display("FAIL b2b_out%0d: got v=%b tag=%0d expected v=1 tag=%0d", k, out_valid, out_tag, k - 1);
        else pass_cnt++;
      end else begin
        if (out_valid !== 1'b0) $display("FAIL b2b_idle%0d: got v=%b expected 0", k, out_valid);
        else pass_cnt++;
      end
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_backpressure();
    int unsigned base;
    @(posedge clk);
    #1;
    base      = out_cnt;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h1234_5678;
    in_amt    = 5'd8;
    in_fn     = 3'b101;
    in_tag    = 5'd5;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        if (c == 1) in_tag = 5'd6;
        if (c == 2) in_tag = 5'd7;
      end
      @(negedge clk);
      chk_cnt++;
      if (in_ready !== (c < 2)) $display("FAIL bp_in_ready%0d: got %b expected %b", c, in_ready, c < 2);
      else pass_cnt++;
      if (c >= 2) begin
        chk_cnt++;
        if (out_valid !== 1'b1 || out_tag !== 5'd5 || out_data !== 32'h7812_3456)
          $display("FAIL bp_hold%0d: got v=%b data=%h tag=%0d expected v=1 data=78123456 tag=5",
                   c, out_valid, out_data, out_tag);
        else pass_cnt++;
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1 in_tag = 5'd8;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk_cnt++;
    if (out_cnt - base != 4) $display("FAIL bp_count: got %0d outputs expected 4", out_cnt - base);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL bp_drain: got %0d pending expected 0", exp_q.size());
    else pass_cnt++;
  endtask

  task automatic test_flush();
    int unsigned base;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_00FF;
    in_amt    = 5'd4;
    in_fn     = 3'b000;
    in_tag    = 5'd10;
    @(negedge clk);
    @(posedge clk);
    #1 in_tag = 5'd11;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL flush_fill_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1;
    in_tag = 5'd12;
    flush  = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b expected 0", in_ready);
    else pass_cnt++;
    base = out_cnt;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b expected 0", out_valid);
    else pass_cnt++;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if (out_cnt != base) $display("FAIL flush_leak: got %0d outputs expected 0", out_cnt - base);
    else pass_cnt++;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'h0F00_0000;
    in_amt   = 5'd12;
    in_fn    = 3'b100;
    in_tag   = 5'd13;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (out_cnt != base + 1) $display("FAIL flush_recover: got %0d outputs expected 1", out_cnt - base);
    else pass_cnt++;
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = 32'hF0F0_0000 | 32'(k + 1);
      in_amt   = 5'd0;
      in_fn    = 3'b000;
      in_tag   = 5'(20 + k);
    end
    @(posedge clk);
    #3;
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL arst_pre_valid: got %b expected 1", out_valid);
    else pass_cnt++;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk_cnt++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_tag !== '0)
      $display("FAIL arst_clear: got v=%b data=%h tag=%0d expected all 0", out_valid, out_data, out_tag);
    else pass_cnt++;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'h8000_0000;
    in_amt   = 5'd31;
    in_fn    = 3'b011;
    in_tag   = 5'd30;
    @(negedge clk);
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL arst_in_ready: got %b expected 1", in_ready);
    else pass_cnt++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b0) $display("FAIL arst_early: got v=%b expected 0", out_valid);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (out_valid !== 1'b1 || out_data !== 32'hFFFF_FFFF || out_tag !== 5'd30)
      $display("FAIL arst_result: got v=%b data=%h tag=%0d expected v=1 data=ffffffff tag=30",
               out_valid, out_data, out_tag);
    else pass_cnt++;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_fn     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_async_reset();
    repeat (3) @(negedge clk);
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL final_drain: got %0d pending expected 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
